// File: rtl/sram_controller.sv
// sram_controller: multi-cycle data-memory controller for the MEM stage.
// Each 32-bit load or store becomes two 16-bit external SRAM accesses: the low half first, then
// the high half. Each half is held on the SRAM bus for WAIT_CYCLES cycles. ready stays low
// while the access is in progress so the pipeline can freeze.
//
// Build option: define SRAM_STALL_CNT_EN to add the stall_count output. It is a saturating
// count of the cycles in which ready was low.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   wr_en        store request
//   rd_en        load request (ignored when wr_en is also set)
//   address      byte address
//   write_data   store data
//   read_data    registered load result, updated when a load completes
//   ready        1 = no access pending, or an access completing this cycle
//   sram_addr    SRAM half-word address
//   sram_dq_out  SRAM write data
//   sram_dq_in   SRAM read data
//   sram_dq_oe   1 = drive sram_dq_out onto the SRAM bus
//   sram_we_n    SRAM write strobe, active low
//   stall_count  (SRAM_STALL_CNT_EN only) saturating count of cycles with ready low
module sram_controller #(
  parameter int unsigned ADDR_BASE   = 1024,
  parameter int unsigned WAIT_CYCLES = 5,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n
`ifdef SRAM_STALL_CNT_EN
  ,
  output logic [31:0]        stall_count
`endif
);

  // The request cycle in IDLE is already the first bus cycle of the low half. The LOW state
  // therefore covers the remaining WAIT_CYCLES-1 cycles. This keeps ready low for exactly
  // 2*WAIT_CYCLES cycles.
  localparam logic [31:0] LowLoad  = (WAIT_CYCLES >= 2) ? 32'(WAIT_CYCLES - 2) : 32'd0;
  localparam logic [31:0] HalfLoad = 32'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

  state_e               state_q, state_d;
  logic [31:0]          cnt_q, cnt_d;
  logic                 op_wr_q, op_wr_d;
  logic [SRAM_AW-2:0]   word_q, word_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [15:0]          lo_q, lo_d;
  logic [31:0]          rdata_q, rdata_d;

  logic                 req;
  logic [31:0]          offset;
  logic [SRAM_AW-2:0]   word_in;

  assign req     = wr_en | rd_en;
  assign offset  = address - 32'(ADDR_BASE);
  // The word index wraps modulo 2^(SRAM_AW-1). Out-of-range addresses are not flagged.
  assign word_in = offset[SRAM_AW:2];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_wr_d     = op_wr_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    lo_d        = lo_q;
    rdata_d     = rdata_q;
    ready       = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;

    unique case (state_q)
      StIdle: begin
        ready = ~req;
        if (req) begin
          op_wr_d   = wr_en;
          word_d    = word_in;
          wdata_d   = write_data;
          // The first low-half cycle is driven from the live inputs. The requester holds them
          // stable from the clock edge onwards.
          sram_addr = {word_in, 1'b0};
          if (wr_en) begin
            sram_dq_out = write_data[15:0];
            sram_dq_oe  = 1'b1;
            sram_we_n   = 1'b0;
          end
          if (WAIT_CYCLES == 1) begin
            if (!wr_en) lo_d = sram_dq_in;
            state_d = StHigh;
            cnt_d   = HalfLoad;
          end else begin
            state_d = StLow;
            cnt_d   = LowLoad;
          end
        end
      end
      StLow: begin
        sram_addr = {word_q, 1'b0};
        if (op_wr_q) begin
          sram_dq_out = wdata_q[15:0];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
        if (cnt_q == 32'd0) begin
          if (!op_wr_q) lo_d = sram_dq_in;
          state_d = StHigh;
          cnt_d   = HalfLoad;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      StHigh: begin
        sram_addr = {word_q, 1'b1};
        if (op_wr_q) begin
          sram_dq_out = wdata_q[31:16];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
        if (cnt_q == 32'd0) begin
          // Both halves are committed together, so read_data holds its old value until this
          // load completes.
          if (!op_wr_q) rdata_d = {sram_dq_in, lo_q};
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      StDone: begin
        ready   = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // While in reset, keep the bus quiet and do not stall the pipeline.
    if (!rst) begin
      ready       = 1'b1;
      sram_addr   = '0;
      sram_dq_out = '0;
      sram_dq_oe  = 1'b0;
      sram_we_n   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
    end
  end

  assign read_data = rdata_q;

`ifdef SRAM_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (!ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller (ADDR_BASE=1024, WAIT_CYCLES=5) with a behavioural
// 16-bit SRAM model.
module tb_sram_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;
`ifdef SRAM_STALL_CNT_EN
  logic [31:0] stall_count;
  logic [31:0] stall_before;
`endif

  int checks = 0;
  int errors = 0;
  logic preload = 1'b1;
  logic [15:0] mem [0:63];

  always #5 clk = ~clk;

  sram_controller #(
    .ADDR_BASE  (1024),
    .WAIT_CYCLES(5),
    .SRAM_AW    (18)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_in (sram_dq_in),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n)
`ifdef SRAM_STALL_CNT_EN
    ,
    .stall_count(stall_count)
`endif
  );

  // SRAM model: writes are captured on the clock edge while we_n is low; reads are asynchronous.
  always @(posedge clk) begin
    if (preload) begin
      mem[0] <= 16'h1111;
      mem[1] <= 16'h2222;
    end else if (!sram_we_n && sram_dq_oe) begin
      mem[sram_addr[5:0]] <= sram_dq_out;
    end
  end
  assign sram_dq_in = mem[sram_addr[5:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts sampling in the current cycle and advances one cycle at a time until ready rises.
  // It counts the ready-low and we_n-low cycles seen along the way.
  task automatic wait_done(output int low_c, output int we_c, output logic [17:0] last_addr);
    low_c = 0;
    we_c  = 0;
    last_addr = '0;
    for (int i = 0; i < 50; i++) begin
      if (ready) break;
      low_c++;
      if (!sram_we_n) we_c++;
      last_addr = sram_addr;
      @(negedge clk);
      #1;
    end
    if (!ready) begin
      errors++;
      $error("FAIL timeout observed=ready_low expected=ready_high");
    end
  endtask

  int          low_c;
  int          we_c;
  logic [17:0] last_a;

  initial begin
    // Reset state
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_oe", 32'(sram_dq_oe), 32'd0);
    check("rst_rdata", read_data, 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    repeat (2) @(negedge clk);
    preload = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // 1: store DEADBEEF @1028
    wr_en = 1'b1; address = 32'd1028; write_data = 32'hDEAD_BEEF;
    #1;
    check("t1_addr_lo", 32'(sram_addr), 32'd2);
    check("t1_dq_lo", 32'(sram_dq_out), 32'h0000_BEEF);
    wait_done(low_c, we_c, last_a);
    check("t1_ready_low", low_c, 32'd10);
    check("t1_we_low", we_c, 32'd10);
    check("t1_addr_hi", 32'(last_a), 32'd3);
    check("t1_we_done", 32'(sram_we_n), 32'd1);
    check("t1_mem2", 32'(mem[2]), 32'h0000_BEEF);
    check("t1_mem3", 32'(mem[3]), 32'h0000_DEAD);
    wr_en = 1'b0;
    @(negedge clk);

    // 2: load @1028
    rd_en = 1'b1; address = 32'd1028;
    #1;
    check("t2_oe", 32'(sram_dq_oe), 32'd0);
    wait_done(low_c, we_c, last_a);
    check("t2_ready_low", low_c, 32'd10);
    check("t2_we_low", we_c, 32'd0);
    check("t2_rdata", read_data, 32'hDEAD_BEEF);
    rd_en = 1'b0;
    @(negedge clk);

    // 3: idle for 20 cycles
    for (int i = 0; i < 20; i++) begin
      #1;
      check("t3_ready", 32'(ready), 32'd1);
      check("t3_we_n", 32'(sram_we_n), 32'd1);
      check("t3_oe", 32'(sram_dq_oe), 32'd0);
      check("t3_rdata", read_data, 32'hDEAD_BEEF);
      @(negedge clk);
    end

    // 4: back-to-back loads @1024 then @1028, with the request held high throughout
    rd_en = 1'b1; address = 32'd1024;
    #1;
    wait_done(low_c, we_c, last_a);
    check("t4a_ready_low", low_c, 32'd10);
    check("t4a_rdata", read_data, 32'h2222_1111);
    address = 32'd1028;
    @(negedge clk);
    #1;
    check("t4_ready_once", 32'(ready), 32'd0);
    wait_done(low_c, we_c, last_a);
    check("t4b_ready_low", low_c, 32'd10);
    check("t4b_rdata", read_data, 32'hDEAD_BEEF);
    rd_en = 1'b0;
    @(negedge clk);

    // 5: reset three cycles into a store, then a clean store @1032
    wr_en = 1'b1; address = 32'd1032; write_data = 32'hCAFE_F00D;
    repeat (3) @(negedge clk);
    #2;
    check("t5_busy", 32'(ready), 32'd0);
    rst = 1'b0;
    #1;
    check("t5_rst_ready", 32'(ready), 32'd1);
    check("t5_rst_we_n", 32'(sram_we_n), 32'd1);
    check("t5_rst_oe", 32'(sram_dq_oe), 32'd0);
    check("t5_rst_addr", 32'(sram_addr), 32'd0);
    check("t5_rst_dq", 32'(sram_dq_out), 32'd0);
    check("t5_rst_rdata", read_data, 32'd0);
    @(negedge clk);
    wr_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    wr_en = 1'b1; address = 32'd1032; write_data = 32'h1234_5678;
    #1;
    wait_done(low_c, we_c, last_a);
    check("t5_ready_low", low_c, 32'd10);
    check("t5_mem4", 32'(mem[4]), 32'h0000_5678);
    check("t5_mem5", 32'(mem[5]), 32'h0000_1234);
    wr_en = 1'b0;
    @(negedge clk);

    // 6: wr_en and rd_en together -> write wins
`ifdef SRAM_STALL_CNT_EN
    stall_before = stall_count;
`endif
    wr_en = 1'b1; rd_en = 1'b1; address = 32'd1024; write_data = 32'hA5A5_5A5A;
    #1;
    wait_done(low_c, we_c, last_a);
    check("t6_ready_low", low_c, 32'd10);
    check("t6_we_low", we_c, 32'd10);
    check("t6_mem0", 32'(mem[0]), 32'h0000_5A5A);
    check("t6_mem1", 32'(mem[1]), 32'h0000_A5A5);
    check("t6_rdata", read_data, 32'd0);
`ifdef SRAM_STALL_CNT_EN
    check("t6_stall", stall_count - stall_before, 32'd10);
`endif
    wr_en = 1'b0; rd_en = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
